mul_pipe: RTL and testbench
===========================

Name: mul_pipe

Overview:
- Parametrised, fully pipelined integer multiplier for the MDU.
- Successor to the fixed two-stage multiplier. It adds:
  - configurable pipeline depth;
  - internal result selection for MUL/MULH/MULHSU/MULHU and the RV64 MULW word form;
  - per-stage valid tracking with stall/flush;
  - a tag carried alongside each operation.
- Accepts one operation per cycle and delivers the XLEN-bit architectural result STAGES cycles later.

Parameters:
- XLEN, 64, operand/result width; legal values are 32 and 64.
- STAGES, 3, register stages from input to output; legal range is 2..4.
- TAGW, 5, width of the opaque tag carried with each operation (e.g. destination register).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- InValid  in  1  an operation is presented this cycle.
- ForwardedSrcA  in  XLEN  multiplicand.
- ForwardedSrcB  in  XLEN  multiplier.
- Funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx is treated as 000.
- WordOp  in  1  MULW. Ignored (forced 0) when XLEN==32.
- TagIn  in  TAGW  tag accompanying the operation.
- Stall  in  1  freeze the entire pipeline.
- Flush  in  1  kill all in-flight operations.
- OutValid  out  1  Result/TagOut are valid this cycle.
- Result  out  XLEN  selected product bits.
- TagOut  out  TAGW  tag of the completing operation.
- Busy  out  1  OR of all stage valid bits.

Behaviour:
- Reset (async, active-high):
  - all stage valid bits clear;
  - OutValid=0, Result=0, TagOut=0, Busy=0;
  - any in-flight operation is discarded; no output is produced after reset deasserts.
- Acceptance and throughput:
  - An operation is accepted when InValid & ~Stall & ~Flush.
  - Throughput is 1 per cycle; there is no back-pressure other than Stall.
- Latency:
  - An op accepted at edge N produces OutValid=1 with its Result and TagOut during the cycle after edge N+STAGES-1 (exactly STAGES cycles, excluding stalls).
  - Each stall cycle adds one cycle of latency.
- Stall:
  - All stage registers, valid bits and outputs hold their values.
  - OutValid stays asserted if it was asserted; the consumer must not double-count under stall.
- Flush:
  - Synchronously clears every stage valid bit and OutValid on the next edge.
  - Data registers may keep stale values.
  - Flush has priority over Stall and over InValid.
- Arithmetic:
  - Operands are extended to XLEN+1 bits:
    - A is sign-extended for MULH and MULHSU, zero-extended otherwise;
    - B is sign-extended for MULH only.
  - The 2*XLEN-bit product is formed from these extended operands.
  - Partial-product generation sits in stage 1. Reduction (CSA) may be split across middle stages. The final CPA and result select sit in the last stage.
  - Any split is allowed as long as latency and results match.
- Result select:
  - MUL: P[XLEN-1:0].
  - MULH/MULHSU/MULHU: P[2*XLEN-1:XLEN].
  - WordOp=1 (XLEN=64 only):
    - the product is formed from the low 32 bits of A and B;
    - Result = sign-extend(P[31:0]) to 64 bits;
    - Funct3 is ignored.
- Operand isolation: when a stage is not valid, its data registers are not required to update. Stall also gates the enable.
- Busy is combinational from the stage valid bits and is not gated by Stall.
- Boundaries:
  - Flush and reset mid-operation both lose every in-flight op.
  - Back-to-back ops with different Funct3 must each use their own captured control, never the current inputs.
  - Most negative × most negative: MULH gives 2^(XLEN-2), MUL gives 0.

Test Plan (XLEN=64, STAGES=3):
- MULHU, A=B=0xFFFF_FFFF_FFFF_FFFF -> Result=0xFFFF_FFFF_FFFF_FFFE, OutValid exactly 3 cycles after accept; MULH on the same operands -> 0x0.
- MULHSU, A=0xFFFF_FFFF_FFFF_FFFF (-1), B=2 -> Result=0xFFFF_FFFF_FFFF_FFFF; MUL, A=0x8000_0000_0000_0000, B=0x8000_0000_0000_0000 -> Result=0, MULH -> 0x4000_0000_0000_0000.
- MULW, A=0x1234_5678_7FFF_FFFF, B=2 -> Result=0xFFFF_FFFF_FFFF_FFFE; MULW A=3, B=5 -> 0xF.
- Four back-to-back ops with tags 1..4 and mixed Funct3 -> four consecutive OutValid cycles, correct per-op results, TagOut 1,2,3,4 in order.
- Stall asserted 2 cycles while 2 ops are in flight -> outputs and Busy frozen, each op completes 2 cycles late with unchanged results; Flush and Stall together -> next cycle Busy=0, OutValid=0, no late outputs.
- Assert reset asynchronously between clock edges with 3 ops in flight -> OutValid/Result/TagOut/Busy go to 0 immediately; after release, a new MUL 7×6 -> Result=42 after 3 cycles with no ghost outputs.

Source files
------------

// File: rtl/mul_pipe.sv
// Pipelined integer multiplier for the MDU (MUL/MULH/MULHSU/MULHU, plus MULW on RV64).
// One op per cycle, result STAGES cycles after acceptance, with a tag carried alongside.
// Ports:
//   clk, reset                 clock, async active-high reset
//   InValid                    operation presented this cycle
//   ForwardedSrcA/B            multiplicand / multiplier (XLEN)
//   Funct3, WordOp             operation select (1xx -> MUL), MULW on XLEN==64
//   TagIn                      opaque tag travelling with the op
//   Stall, Flush               freeze pipeline / kill all in-flight ops (Flush wins)
//   OutValid, Result, TagOut   registered completion
//   Busy                       combinational OR of every stage valid bit
module mul_pipe #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STAGES = 3,
    parameter int unsigned TAGW   = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            InValid,
    input  logic [XLEN-1:0] ForwardedSrcA,
    input  logic [XLEN-1:0] ForwardedSrcB,
    input  logic [2:0]      Funct3,
    input  logic            WordOp,
    input  logic [TAGW-1:0] TagIn,
    input  logic            Stall,
    input  logic            Flush,
    output logic            OutValid,
    output logic [XLEN-1:0] Result,
    output logic [TAGW-1:0] TagOut,
    output logic            Busy
);
    localparam int unsigned PW       = 2 * XLEN;
    localparam int unsigned MID      = STAGES - 2;
    localparam bit          HAS_WORD = (XLEN == 64);

    // Operand/control decode at the input
    logic            acc, word, hi, a_sgn, b_sgn;
    logic [XLEN-1:0] a_src, b_src;

    always_comb begin
        acc   = InValid & ~Stall & ~Flush;
        word  = WordOp & HAS_WORD;
        hi    = 1'b0;
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        if (!word && !Funct3[2]) begin
            case (Funct3[1:0])
                2'b01:   begin hi = 1'b1; a_sgn = 1'b1; b_sgn = 1'b1; end
                2'b10:   begin hi = 1'b1; a_sgn = 1'b1; end
                2'b11:   hi = 1'b1;
                default: ;
            endcase
        end
        // Word form only needs the low product bits, so zero-extended low halves suffice
        a_src = word ? XLEN'(ForwardedSrcA[31:0]) : ForwardedSrcA;
        b_src = word ? XLEN'(ForwardedSrcB[31:0]) : ForwardedSrcB;
    end

    // Stage 1: extended operands and captured control
    logic            v1, hi1, w1;
    logic [XLEN:0]   a1, b1;
    logic [TAGW-1:0] t1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       v1 <= 1'b0;
        else if (Flush)  v1 <= 1'b0;
        else if (!Stall) v1 <= InValid;
    end

    always_ff @(posedge clk) begin
        if (acc) begin
            a1  <= {a_sgn & a_src[XLEN-1], a_src};
            b1  <= {b_sgn & b_src[XLEN-1], b_src};
            hi1 <= hi;
            w1  <= word;
            t1  <= TagIn;
        end
    end

    // Product of the (XLEN+1)-bit signed operands, kept modulo 2^(2*XLEN)
    logic [PW-1:0] prod1;
    assign prod1 = {{(XLEN-1){a1[XLEN]}}, a1} * {{(XLEN-1){b1[XLEN]}}, b1};

    // Source of the final stage: stage 1 directly, or the last middle register
    logic            src_v, src_hi, src_w, mid_busy;
    logic [PW-1:0]   src_p;
    logic [TAGW-1:0] src_t;

    if (MID == 0) begin : g_nomid
        assign src_v    = v1;
        assign src_p    = prod1;
        assign src_hi   = hi1;
        assign src_w    = w1;
        assign src_t    = t1;
        assign mid_busy = 1'b0;
    end else begin : g_mid
        logic [MID-1:0]  vm, hm, wm;
        logic [PW-1:0]   pm [MID];
        logic [TAGW-1:0] tm [MID];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vm <= '0;
            end else if (Flush) begin
                vm <= '0;
            end else if (!Stall) begin
                vm[0] <= v1;
                for (int i = 1; i < int'(MID); i++) vm[i] <= vm[i-1];
            end
        end

        // Data registers only load behind a valid upstream stage
        always_ff @(posedge clk) begin
            if (!Stall && v1) begin
                pm[0] <= prod1;
                hm[0] <= hi1;
                wm[0] <= w1;
                tm[0] <= t1;
            end
            for (int i = 1; i < int'(MID); i++) begin
                if (!Stall && vm[i-1]) begin
                    pm[i] <= pm[i-1];
                    hm[i] <= hm[i-1];
                    wm[i] <= wm[i-1];
                    tm[i] <= tm[i-1];
                end
            end
        end

        assign src_v    = vm[MID-1];
        assign src_p    = pm[MID-1];
        assign src_hi   = hm[MID-1];
        assign src_w    = wm[MID-1];
        assign src_t    = tm[MID-1];
        assign mid_busy = |vm;
    end

    // Final stage: result select
    logic [XLEN-1:0] sel;
    always_comb begin
        sel = src_p[XLEN-1:0];
        if (src_w)       sel = XLEN'($signed(src_p[31:0]));
        else if (src_hi) sel = src_p[PW-1:XLEN];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            OutValid <= 1'b0;
            Result   <= '0;
            TagOut   <= '0;
        end else if (Flush) begin
            OutValid <= 1'b0;
        end else if (!Stall) begin
            OutValid <= src_v;
            if (src_v) begin
                Result <= sel;
                TagOut <= src_t;
            end
        end
    end

    assign Busy = v1 | mid_busy | OutValid;

endmodule

// File: tb/tb_mul_pipe.sv
module tb_mul_pipe;
    localparam int unsigned XLEN = 64;
    localparam int unsigned TAGW = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            InValid;
    logic [XLEN-1:0] ForwardedSrcA, ForwardedSrcB;
    logic [2:0]      Funct3;
    logic            WordOp;
    logic [TAGW-1:0] TagIn;
    logic            Stall, Flush;
    logic            OutValid;
    logic [XLEN-1:0] Result;
    logic [TAGW-1:0] TagOut;
    logic            Busy;

    mul_pipe #(.XLEN(XLEN), .STAGES(3), .TAGW(TAGW)) dut (
        .clk(clk), .reset(reset), .InValid(InValid),
        .ForwardedSrcA(ForwardedSrcA), .ForwardedSrcB(ForwardedSrcB),
        .Funct3(Funct3), .WordOp(WordOp), .TagIn(TagIn),
        .Stall(Stall), .Flush(Flush),
        .OutValid(OutValid), .Result(Result), .TagOut(TagOut), .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0]     res;
        logic [TAGW-1:0] tag;
        int              due;
    } sb_t;

    sb_t         sb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        held_ov, held_busy;
    logic [63:0] held_res;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Independent reference: full 128-bit products of the architecturally extended operands
    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] f, input logic w);
        logic [127:0] p;
        if (w) begin
            p = {96'b0, a[31:0]} * {96'b0, b[31:0]};
            return {{32{p[31]}}, p[31:0]};
        end
        case (f)
            3'b001:  p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
            3'b010:  p = {{64{a[63]}}, a} * {64'b0, b};
            3'b011:  p = {64'b0, a} * {64'b0, b};
            default: p = {64'b0, a} * {64'b0, b};
        endcase
        return (f == 3'b001 || f == 3'b010 || f == 3'b011) ? p[127:64] : p[63:0];
    endfunction

    task automatic snap();
        held_ov   = OutValid;
        held_busy = Busy;
        held_res  = Result;
    endtask

    // One clock with scoreboard bookkeeping; inputs seen at this edge are the current ones
    task automatic step();
        logic st, fl;
        sb_t  e;
        st = Stall;
        fl = Flush;
        @(posedge clk);
        #1;
        cyc++;
        if (fl) begin
            sb.delete();
            chk("flush_outvalid", 64'(OutValid), 64'd0);
            chk("flush_busy", 64'(Busy), 64'd0);
        end else if (st) begin
            for (int i = 0; i < sb.size(); i++) sb[i].due++;
            chk("stall_outvalid", 64'(OutValid), 64'(held_ov));
            chk("stall_result", Result, held_res);
            chk("stall_busy", 64'(Busy), 64'(held_busy));
        end else if (OutValid) begin
            if (sb.size() == 0) begin
                chk("ghost_outvalid", 64'(OutValid), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("latency", 64'(cyc), 64'(e.due));
                chk("result", Result, e.res);
                chk("tagout", 64'(TagOut), 64'(e.tag));
            end
        end else if (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("missing_outvalid", 64'(OutValid), 64'd1);
            void'(sb.pop_front());
        end
        snap();
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] f,
                         input logic w, input logic [TAGW-1:0] tag, input logic [63:0] exp);
        sb_t e;
        InValid       = 1'b1;
        ForwardedSrcA = a;
        ForwardedSrcB = b;
        Funct3        = f;
        WordOp        = w;
        TagIn         = tag;
        if (!Stall && !Flush) begin
            e.res = exp;
            e.tag = tag;
            e.due = cyc + 3;
            sb.push_back(e);
        end
        step();
        InValid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [63:0] a, b;
        reset = 1'b1; InValid = 1'b0; ForwardedSrcA = '0; ForwardedSrcB = '0;
        Funct3 = 3'b000; WordOp = 1'b0; TagIn = '0; Stall = 1'b0; Flush = 1'b0;
        #1;
        chk("reset_outvalid", 64'(OutValid), 64'd0);
        chk("reset_result", Result, 64'd0);
        chk("reset_tagout", 64'(TagOut), 64'd0);
        chk("reset_busy", 64'(Busy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        snap();

        // Directed arithmetic corners, each spaced out
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b011, 1'b0, 5'd10, 64'hFFFF_FFFF_FFFF_FFFE);
        idle(3);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'b001, 1'b0, 5'd11, 64'h0);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 3'b010, 1'b0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b000, 1'b0, 5'd13, 64'h0);
        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b001, 1'b0, 5'd14, 64'h4000_0000_0000_0000);
        issue(64'h1234_5678_7FFF_FFFF, 64'd2, 3'b011, 1'b1, 5'd15, 64'hFFFF_FFFF_FFFF_FFFE);
        issue(64'd3, 64'd5, 3'b001, 1'b1, 5'd16, 64'hF);
        issue(64'd9, 64'd9, 3'b100, 1'b0, 5'd17, 64'd81);
        idle(4);

        // Back-to-back, mixed Funct3, tags 1..4
        issue(-64'sd3, 64'd7, 3'b001, 1'b0, 5'd1, model(-64'sd3, 64'd7, 3'b001, 1'b0));
        issue(64'h1_2345_6789, 64'h1000, 3'b000, 1'b0, 5'd2, model(64'h1_2345_6789, 64'h1000, 3'b000, 1'b0));
        issue(64'h8000_0000_0000_0000, 64'd4, 3'b011, 1'b0, 5'd3, 64'd2);
        issue(-64'sd5, 64'hFFFF_0000_0000_0001, 3'b010, 1'b0, 5'd4,
              model(-64'sd5, 64'hFFFF_0000_0000_0001, 3'b010, 1'b0));
        idle(4);

        // A few random ops against the reference model
        for (int i = 0; i < 6; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            issue(a, b, 3'(i), 1'(i == 5), 5'(20 + i), model(a, b, 3'(i), 1'(i == 5)));
        end
        idle(4);

        // Stall two cycles with two ops in flight
        issue(64'd100, 64'd3, 3'b000, 1'b0, 5'd5, 64'd300);
        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b001, 1'b0, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("inflight_busy", 64'(Busy), 64'd1);
        Stall = 1'b1;
        idle(2);
        Stall = 1'b0;
        idle(4);

        // Flush together with Stall kills everything
        issue(64'd11, 64'd11, 3'b000, 1'b0, 5'd7, 64'd121);
        issue(64'd12, 64'd12, 3'b000, 1'b0, 5'd8, 64'd144);
        Stall = 1'b1;
        Flush = 1'b1;
        InValid = 1'b1;
        step();
        Stall = 1'b0;
        Flush = 1'b0;
        InValid = 1'b0;
        idle(5);

        // Asynchronous reset mid-cycle with three ops in flight
        issue(64'd2, 64'd2, 3'b000, 1'b0, 5'd9, 64'd4);
        issue(64'd3, 64'd3, 3'b000, 1'b0, 5'd10, 64'd9);
        issue(64'd4, 64'd4, 3'b000, 1'b0, 5'd11, 64'd16);
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_outvalid", 64'(OutValid), 64'd0);
        chk("async_rst_result", Result, 64'd0);
        chk("async_rst_tagout", 64'(TagOut), 64'd0);
        chk("async_rst_busy", 64'(Busy), 64'd0);
        sb.delete();
        @(posedge clk);
        cyc++;
        #1;
        reset = 1'b0;
        snap();
        issue(64'd7, 64'd6, 3'b000, 1'b0, 5'd12, 64'd42);
        idle(5);

        for (int i = 0; i < 20 && sb.size() > 0; i++) step();
        chk("drain_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
